ptp_rtc_unit: RTL

Free-running PTPv2 real-time clock that produces the 80-bit time (48-bit seconds, 32-bit nanoseconds) and 16-bit fractional nanoseconds consumed by the timestamp unit on its `rtc_std_i` / `rtc_fns_i` inputs. It adds a programmable per-cycle increment every clock. A valid/ready command port lets software servo logic load absolute time, step a signed nanosecond offset, and set a fine drift correction. It also emits a pulse-per-second on every natural seconds rollover.

---
 rtl/ptp_rtc_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ptp_rtc_unit.sv
// PTPv2 real-time clock: free-running {sec, ns, fns} time base with a per-cycle increment,
// fine drift correction, and a two-cycle command port for load, offset step and drift setup.
module ptp_rtc_unit #(
  parameter int unsigned NS_PER_SEC = 1_000_000_000
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst_n,
  input  logic [23:0] tick_inc_i,
  input  logic        cmd_vld_i,
  output logic        cmd_rdy_o,
  input  logic [1:0]  cmd_op_i,
  input  logic        cmd_neg_i,
  input  logic [47:0] cmd_sec_i,
  input  logic [31:0] cmd_ns_i,
  output logic [79:0] rtc_std_o,
  output logic [15:0] rtc_fns_o,
  output logic        pps_o,
  output logic        time_vld_o
);

  // Handshake: a command transfers on a rising edge where cmd_vld_i && cmd_rdy_o; cmd_rdy_o is
  // high only in IDLE, so after each transfer the port is closed for exactly one APPLY cycle.

  typedef enum logic {IDLE, APPLY} state_t;

  localparam logic [1:0]  OP_LOAD  = 2'b00;
  localparam logic [1:0]  OP_STEP  = 2'b01;
  localparam logic [1:0]  OP_DRIFT = 2'b10;
  localparam logic [33:0] NS1      = 34'(NS_PER_SEC);
  localparam logic [33:0] NS2      = NS1 << 1;

  state_t      state, state_nxt;
  logic [47:0] sec;
  logic [31:0] ns;
  logic [15:0] fns;
  logic [23:0] drift_period, drift_cnt;
  logic        drift_neg;
  logic [1:0]  cmd_op_q;
  logic        cmd_neg_q;
  logic [47:0] cmd_sec_q;
  logic [31:0] cmd_ns_q;
  logic        time_vld, pps;

  logic        is_load, is_step, is_drift, xfer;
  logic        drift_fire, sec_up;
  logic [17:0] drift_adj, fns_sum;
  logic [33:0] step_adj, ns_sum, ns_norm;
  logic [47:0] sec_norm;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_vld_i) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_rdy_o = (state == IDLE);
  assign xfer      = cmd_vld_i && (state == IDLE);
  assign is_load   = (state == APPLY) && (cmd_op_q == OP_LOAD);
  assign is_step   = (state == APPLY) && (cmd_op_q == OP_STEP);
  assign is_drift  = (state == APPLY) && (cmd_op_q == OP_DRIFT);

  always_comb begin
    drift_fire = (drift_period != 24'd0) && (drift_cnt == drift_period - 24'd1);
    drift_adj  = 18'd0;
    if (drift_fire) drift_adj = drift_neg ? 18'h3FFFF : 18'd1;
    // fns_sum[17:16] is the signed carry into ns: 01 = +1, 11 = -1.
    fns_sum  = {2'b00, fns} + {2'b00, tick_inc_i[15:0]} + drift_adj;
    step_adj = 34'd0;
    if (is_step) step_adj = cmd_neg_q ? (34'd0 - {2'b00, cmd_ns_q}) : {2'b00, cmd_ns_q};
    ns_sum = {2'b00, ns} + {26'd0, tick_inc_i[23:16]}
           + {{32{fns_sum[17]}}, fns_sum[17:16]} + step_adj;
    ns_norm  = ns_sum;
    sec_norm = sec;
    sec_up   = 1'b0;
    if (ns_sum[33]) begin
      ns_norm  = ns_sum + NS1;
      sec_norm = sec - 48'd1;
    end else if (ns_sum >= NS2) begin
      ns_norm  = ns_sum - NS2;
      sec_norm = sec + 48'd2;
      sec_up   = 1'b1;
    end else if (ns_sum >= NS1) begin
      ns_norm  = ns_sum - NS1;
      sec_norm = sec + 48'd1;
      sec_up   = 1'b1;
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      state        <= IDLE;
      sec          <= '0;
      ns           <= '0;
      fns          <= '0;
      drift_period <= '0;
      drift_cnt    <= '0;
      drift_neg    <= 1'b0;
      cmd_op_q     <= '0;
      cmd_neg_q    <= 1'b0;
      cmd_sec_q    <= '0;
      cmd_ns_q     <= '0;
      time_vld     <= 1'b0;
      pps          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        cmd_op_q  <= cmd_op_i;
        cmd_neg_q <= cmd_neg_i;
        cmd_sec_q <= cmd_sec_i;
        cmd_ns_q  <= cmd_ns_i;
      end
      // A load replaces the whole time value; the tick of that cycle is dropped.
      if (is_load) begin
        sec      <= cmd_sec_q;
        ns       <= cmd_ns_q;
        fns      <= '0;
        time_vld <= 1'b1;
      end else begin
        sec <= sec_norm;
        ns  <= ns_norm[31:0];
        fns <= fns_sum[15:0];
      end
      pps <= sec_up && !is_load && !is_step;
      if (is_drift) begin
        drift_period <= cmd_ns_q[23:0];
        drift_neg    <= cmd_neg_q;
        drift_cnt    <= '0;
      end else if (drift_period == 24'd0 || drift_fire) begin
        drift_cnt <= '0;
      end else begin
        drift_cnt <= drift_cnt + 24'd1;
      end
    end
  end

  assign rtc_std_o  = {sec, ns};
  assign rtc_fns_o  = fns;
  assign pps_o      = pps;
  assign time_vld_o = time_vld;

endmodule
